filter_arbiter: RTL and testbench
=================================

FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of all bits ports.
REQ-002 Parameter THRESH, default 10, exclusive upper bound of the pass predicate.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0, released at 1).
REQ-005 in0_valid  in  1  requester 0 beat present.
REQ-006 in0_ready  out  1  requester 0 beat consumed this cycle.
REQ-007 in0_bits  in  WIDTH  requester 0 data.
REQ-008 in1_valid / in1_ready / in1_bits  in / out / in  1 / 1 / WIDTH  requester 1, same meaning as port 0.
REQ-009 out_valid  out  1  output register holds a passed beat.
REQ-010 out_ready  in  1  downstream accepts the output beat.
REQ-011 out_bits  out  WIDTH  passed data.
REQ-012 out_src  out  1  index of the requester that supplied out_bits.
REQ-013 drop_count  out  16  number of beats rejected by the predicate (present only with FILTER_ARB_DROP_CNT_EN).

Function
REQ-014 Predicate: pass = (bits < THRESH) AND bits[0]; unsigned compare at full WIDTH.
REQ-015 Handshakes: transfer on a port when valid AND ready in the same cycle; valid SHALL NOT depend on ready.
REQ-016 Output stage: one-entry register; can_accept = !out_valid OR out_ready.
REQ-017 Arbitration: at most one input granted per cycle; grant only when can_accept is 1.
REQ-018 Round-robin: 1-bit pointer prio; if both valid, grant port prio; if one valid, grant it regardless of prio.
REQ-019 On any grant to port k, prio <= !k next cycle; no grant -> prio holds.
REQ-020 inK_ready = grant to port K; a non-granted port sees ready 0.
REQ-021 Granted beat passing predicate: out_valid <= 1, out_bits <= bits, out_src <= k next cycle (latency 1).
REQ-022 Granted beat failing predicate: consumed (ready 1), discarded, output register unchanged except as REQ-023.
REQ-023 out_valid AND out_ready with no new passed beat: out_valid <= 0 next cycle; out_bits/out_src hold.
REQ-024 Simultaneous drain and load (out_ready 1 and passed grant): register reloads, out_valid stays 1; full throughput of one beat per cycle.
REQ-025 out_valid 1 and out_ready 0: out_bits/out_src stable, no grants, both in*_ready 0.
REQ-026 Dropped beats still advance prio; a rejecting requester cannot starve the other.

Reset
REQ-027 Reset assertion immediately forces out_valid 0, out_bits 0, out_src 0, prio 0, drop_count 0, regardless of clock.
REQ-028 During reset in0_ready and in1_ready SHALL be 0.
REQ-029 Reset mid-transfer discards the held output beat; no beat is emitted after release until a new grant.
REQ-030 First grant after release with both valid goes to port 0.

Configuration
REQ-031 Macro FILTER_ARB_DROP_CNT_EN defined: drop_count port and 16-bit counter present; +1 per rejected granted beat; saturates at 0xFFFF (no wrap).
REQ-032 Macro undefined: drop_count port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset then in0_valid=1 bits=3, out_ready=1 -> in0_ready=1 that cycle; next cycle out_valid=1, out_bits=3, out_src=0.
REQ-034 Both valid every cycle, in0=5, in1=7, out_ready=1 -> grants alternate 0,1,0,1; out_src alternates, one beat per cycle.
REQ-035 in0 bits=4 (even), then bits=11 (>=10) -> both consumed, out_valid stays 0, drop_count=2.
REQ-036 out_valid=1 with out_bits=9, out_ready=0 for 5 cycles while in1_valid=1 -> in1_ready=0, out_bits=9 stable; out_ready=1 -> drain and reload same cycle.
REQ-037 With FILTER_ARB_DROP_CNT_EN, force 65536 rejected beats -> drop_count=0xFFFF, holds on further drops.
REQ-038 Assert reset while out_valid=1 -> out_valid=0 immediately, in*_ready=0; release with both valid -> port 0 granted first.

Source files
------------

// File: rtl/filter_arbiter.sv
// filter_arbiter: two-input round-robin arbiter feeding a one-entry output register through a pass filter
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in0_valid/in0_ready/in0_bits      requester 0 (valid/ready handshake)
//   in1_valid/in1_ready/in1_bits      requester 1 (valid/ready handshake)
//   out_valid/out_ready/out_bits      filtered output stream
//   out_src                           requester index that supplied out_bits
//   drop_count                        saturating count of rejected beats (only with FILTER_ARB_DROP_CNT_EN)
// A beat passes when bits < THRESH and bits is odd; rejected beats are consumed and discarded.
module filter_arbiter #(
    parameter int WIDTH  = 16,
    parameter int THRESH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_bits,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic             out_src
`ifdef FILTER_ARB_DROP_CNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_bits_q, out_bits_d;
    logic             out_src_q, out_src_d;
    logic             prio_q, prio_d;
    logic             can_accept, grant0, grant1, any_grant, pass, load;
    logic [WIDTH-1:0] gnt_bits;

    always_comb begin
        can_accept = !out_valid_q || out_ready;
        // With both valid the pointer picks; a lone requester wins regardless of the pointer.
        grant0     = can_accept && in0_valid && (!in1_valid || !prio_q);
        grant1     = can_accept && in1_valid && (!in0_valid || prio_q);
        any_grant  = grant0 || grant1;
        gnt_bits   = grant1 ? in1_bits : in0_bits;
        pass       = (gnt_bits < THRESH_W) && gnt_bits[0];
        load       = any_grant && pass;
        out_valid_d = load || (out_valid_q && !out_ready);
        out_bits_d  = load ? gnt_bits : out_bits_q;
        out_src_d   = load ? grant1 : out_src_q;
        // Dropped beats also move the pointer so a rejecting requester cannot starve the other.
        prio_d      = any_grant ? grant0 : prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_src_q   <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_src_q   <= out_src_d;
            prio_q      <= prio_d;
        end
    end

    // Readies are masked by reset so nothing is consumed while the register is held clear.
    assign in0_ready = grant0 && rst_n;
    assign in1_ready = grant1 && rst_n;
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_src   = out_src_q;

`ifdef FILTER_ARB_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = (any_grant && !pass && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_filter_arbiter.sv
// tb_filter_arbiter: directed self-checking bench for filter_arbiter
module tb_filter_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in0_ready, in1_valid, in1_ready;
    logic [15:0] in0_bits, in1_bits, out_bits;
    logic        out_valid, out_ready, out_src;
    int          tests = 0;
    int          fails = 0;
`ifdef FILTER_ARB_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    filter_arbiter #(.WIDTH(16), .THRESH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_bits(in0_bits),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_bits(in1_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .out_src(out_src)
`ifdef FILTER_ARB_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [15:0] b0, input logic v1, input logic [15:0] b1, input logic ordy);
        in0_valid = v0; in0_bits = b0; in1_valid = v1; in1_bits = b1; out_ready = ordy;
    endtask

    initial begin
        logic exp_src;
        rst_n = 1'b1;
        drive(1, 16'd5, 1, 16'd7, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        tick();
        tick();
        chk("rst_hold_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 16'd3, 0, 16'd0, 1);
        #1;
        chk("single_in0_ready", in0_ready, 1);
        chk("single_in1_ready", in1_ready, 0);
        tick();
        chk("single_out_valid", out_valid, 1);
        chk("single_out_bits", out_bits, 3);
        chk("single_out_src", out_src, 0);
        drive(0, 16'd0, 0, 16'd0, 1);
        tick();
        chk("drain_out_valid", out_valid, 0);
        chk("drain_out_bits_hold", out_bits, 3);
        // prio is 1 after the grant to port 0, so the alternation starts at port 1
        drive(1, 16'd5, 1, 16'd7, 1);
        exp_src = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #0;
            chk("rr_in0_ready", in0_ready, !exp_src);
            chk("rr_in1_ready", in1_ready, exp_src);
            tick();
            chk("rr_out_valid", out_valid, 1);
            chk("rr_out_src", out_src, exp_src);
            chk("rr_out_bits", out_bits, exp_src ? 16'd7 : 16'd5);
            exp_src = !exp_src;
        end
        drive(0, 16'd0, 0, 16'd0, 1);
        tick();
        chk("rr_drain", out_valid, 0);
        drive(1, 16'd4, 0, 16'd0, 1);
        #1;
        chk("even_in0_ready", in0_ready, 1);
        tick();
        chk("even_out_valid", out_valid, 0);
        drive(1, 16'd11, 0, 16'd0, 1);
        #1;
        chk("big_in0_ready", in0_ready, 1);
        tick();
        chk("big_out_valid", out_valid, 0);
        drive(1, 16'h8001, 0, 16'd0, 1);
        tick();
        chk("wide_out_valid", out_valid, 0);
`ifdef FILTER_ARB_DROP_CNT_EN
        chk("drop_count_3", drop_count, 3);
`endif
        drive(1, 16'd9, 0, 16'd0, 0);
        #1;
        chk("load9_in0_ready", in0_ready, 1);
        tick();
        chk("load9_out_valid", out_valid, 1);
        chk("load9_out_bits", out_bits, 9);
        chk("load9_out_src", out_src, 0);
        drive(0, 16'd0, 1, 16'd1, 0);
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("stall_in1_ready", in1_ready, 0);
            chk("stall_in0_ready", in0_ready, 0);
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_bits", out_bits, 9);
        end
        out_ready = 1'b1;
        #1;
        chk("reload_in1_ready", in1_ready, 1);
        tick();
        chk("reload_out_valid", out_valid, 1);
        chk("reload_out_bits", out_bits, 1);
        chk("reload_out_src", out_src, 1);
        // prio now 0: port 0 is granted and rejected, then port 1 must still get through
        drive(1, 16'd4, 1, 16'd3, 1);
        #1;
        chk("starve_in0_ready", in0_ready, 1);
        chk("starve_in1_ready0", in1_ready, 0);
        tick();
        chk("starve_out_valid0", out_valid, 0);
        chk("starve_in1_ready", in1_ready, 1);
        tick();
        chk("starve_out_valid1", out_valid, 1);
        chk("starve_out_bits", out_bits, 3);
        chk("starve_out_src", out_src, 1);
`ifdef FILTER_ARB_DROP_CNT_EN
        chk("drop_count_4", drop_count, 4);
`endif
        drive(1, 16'd5, 1, 16'd7, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_bits", out_bits, 0);
        chk("midrst_out_src", out_src, 0);
        chk("midrst_in0_ready", in0_ready, 0);
        chk("midrst_in1_ready", in1_ready, 0);
`ifdef FILTER_ARB_DROP_CNT_EN
        chk("midrst_drop_count", drop_count, 0);
`endif
        tick();
        chk("midrst_hold_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_in0_ready", in0_ready, 1);
        chk("post_in1_ready", in1_ready, 0);
        tick();
        chk("post_out_src", out_src, 0);
        chk("post_out_bits", out_bits, 5);
`ifdef FILTER_ARB_DROP_CNT_EN
        drive(1, 16'd0, 0, 16'd0, 1);
        for (int i = 0; i < 65536; i++) @(posedge clk);
        #1;
        chk("sat_drop_count", drop_count, 16'hFFFF);
        tick();
        tick();
        chk("sat_hold", drop_count, 16'hFFFF);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
